// File: rtl/simp_arbiter.sv
// Round-robin arbiter sharing one simp slave port between NUM_MASTERS simp masters.
// Optional watchdog enabled by defining SIMP_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module simp_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS*32-1:0]   m_addr,
    input  logic [NUM_MASTERS*32-1:0]   m_data_in,
    input  logic [NUM_MASTERS-1:0]      m_wr,
    input  logic [NUM_MASTERS-1:0]      m_rd,
    input  logic [NUM_MASTERS-1:0]      m_valid,
    input  logic [NUM_MASTERS*4-1:0]    m_be,
    output logic [NUM_MASTERS*32-1:0]   m_data_out,
    output logic [NUM_MASTERS-1:0]      m_done,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_data_in,
    output logic                        s_wr,
    output logic                        s_rd,
    output logic                        s_valid,
    output logic [3:0]                  s_be,
    input  logic [31:0]                 s_data_out,
    input  logic                        s_done,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        busy_o,
    output logic                        timeout_err_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]   last_grant_reg, last_grant_next;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               timeout_fire;
    logic               xfer_active;
    logic               done_any;
    logic [31:0]        resp_data;

    // Round-robin pick: first requester strictly after the last winner, wrapping.
    always_comb begin : p_select
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand     = (int'(last_grant_reg) + i) % NUM_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!sel_found && m_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

`ifdef SIMP_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_err_reg;

    assign timeout_fire = (state_reg == BUSY) && !s_done && (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = '0;
        if (state_reg == BUSY && !s_done) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (timeout_fire) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_reg;
`else
    assign timeout_fire  = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next      = BUSY;
                    grant_next      = sel_idx;
                    last_grant_next = sel_idx;
                end
            end
            BUSY: begin
                // The grant is held until completion even if the master withdraws valid.
                if (s_done || timeout_fire) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Slave side is a pure mux of the granted master; forced to zero outside a live access.
    assign xfer_active = (state_reg == BUSY) && !timeout_fire;
    assign busy_o      = (state_reg == BUSY);

    always_comb begin
        s_addr    = '0;
        s_data_in = '0;
        s_wr      = 1'b0;
        s_rd      = 1'b0;
        s_valid   = 1'b0;
        s_be      = '0;
        if (xfer_active) begin
            s_addr    = m_addr[grant_reg*32 +: 32];
            s_data_in = m_data_in[grant_reg*32 +: 32];
            s_wr      = m_wr[grant_reg];
            s_rd      = m_rd[grant_reg];
            s_valid   = 1'b1;
            s_be      = m_be[grant_reg*4 +: 4];
        end
    end

    assign done_any  = s_done || timeout_fire;
    assign resp_data = timeout_fire ? 32'hDEAD_BEEF : s_data_out;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign grant_o[gi]              = (state_reg == BUSY) && (grant_reg == IDX_W'(gi));
            assign m_done[gi]               = grant_o[gi] && done_any;
            assign m_data_out[gi*32 +: 32]  = grant_o[gi] ? resp_data : 32'h0;
        end
    endgenerate

endmodule

// File: doc/simp_arbiter.md
Name: simp_arbiter

Overview:
- Round-robin arbiter that shares one simp slave (memory or peripheral port) between NUM_MASTERS simp masters, e.g. I-fetch, D-access and the AXI-Lite bridge.
- Grants one master per transaction and forwards its request to the slave. Routes done and data_out back to that master only.
- Sits between the simp masters and the shared memory port.

Parameters:
- NUM_MASTERS, 2, number of requesting simp masters (2..8).
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when SIMP_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m_addr  in  NUM_MASTERS*32  per-master address; master i at bits [32i+31:32i].
- m_data_in  in  NUM_MASTERS*32  per-master write data.
- m_wr  in  NUM_MASTERS  per-master write request.
- m_rd  in  NUM_MASTERS  per-master read request.
- m_valid  in  NUM_MASTERS  per-master valid.
- m_be  in  NUM_MASTERS*4  per-master byte enables.
- m_data_out  out  NUM_MASTERS*32  per-master read data.
- m_done  out  NUM_MASTERS  per-master done.
- s_addr  out  32  slave address.
- s_data_in  out  32  slave write data.
- s_wr  out  1  slave write request.
- s_rd  out  1  slave read request.
- s_valid  out  1  slave valid.
- s_be  out  4  slave byte enables.
- s_data_out  in  32  slave read data.
- s_done  in  1  slave done.
- grant_o  out  NUM_MASTERS  one-hot current grant; all zero when idle.
- busy_o  out  1  high while a transaction is in flight.
- timeout_err_o  out  1  sticky watchdog error flag.

Behaviour:
- Reset: rst is asynchronous and active-high. On rst, state=IDLE, grant=0 and last_grant=NUM_MASTERS-1, so master 0 has top priority after reset.
  - Every output is 0 immediately on reset, including mid-transaction; an in-flight slave access is abandoned.
- Simp rules enforced toward masters:
  - done is a single-cycle pulse.
  - data_out is valid in the done cycle.
- State IDLE:
  - s_valid=0, busy_o=0, grant_o=0.
  - If any m_valid is set, select the first set bit searching from last_grant+1 upward, with modulo wrap.
  - At the next edge: grant<=selected, last_grant<=selected, state<=BUSY.
  - If no m_valid is set, stay in IDLE.
- State BUSY:
  - s_addr, s_data_in, s_wr, s_rd, s_be and s_valid=1 are driven combinationally from the granted master's inputs.
  - busy_o=1, grant_o=grant.
  - m_done[g]=s_done and m_data_out[g]=s_data_out. For all other masters, done=0 and data_out=0.
  - When s_done=1, the next state is IDLE and grant is cleared.
  - The grant is held until s_done even if the granted master drops m_valid (protocol violation, not repaired).
- Latency:
  - A request seen in IDLE at cycle k drives s_valid in cycle k+1.
  - If the slave answers in the same cycle, m_done pulses in cycle k+1.
  - Minimum spacing is one IDLE cycle between transactions, i.e. 2 cycles per transaction.
- Fairness:
  - A master that just completed has lowest priority at the next arbitration.
  - With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Simultaneous events:
  - s_done together with new m_valid requests: complete the transaction first, then arbitrate in the following IDLE cycle.
  - m_wr and m_rd both set are forwarded unchanged.
- Outputs toward the slave are 0 whenever state=IDLE.

Optional Feature:
SIMP_ARB_TIMEOUT_EN
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle without s_done. When it reaches TIMEOUT_CYCLES-1 without s_done:
  - pulse m_done[g]=1 with m_data_out[g]=32'hDEAD_BEEF;
  - drop s_valid;
  - set timeout_err_o=1, which is sticky until rst;
  - return to IDLE.
  - A late s_done arriving in IDLE is ignored.
- Undefined: no counter; timeout_err_o is tied to 0 and BUSY waits indefinitely.

Test Plan:
- Single master 0 read, addr=0x100; slave answers done after 3 cycles with 0x12345678 -> s_valid high 3 cycles, s_addr=0x100, s_be from m_be, one-cycle m_done[0] with m_data_out[0]=0x12345678, m_done[1]=0.
- Masters 0 and 1 raise valid in the same cycle after reset; slave always 1-cycle done -> grant order 0,1,0,1 over 4 transactions; grant_o one-hot, never 2'b11.
- Master 1 write addr=0x40, data=0xA5A5A5A5, be=4'b0011 -> slave sees exactly these values while s_valid=1; m_done[1] pulses once; busy_o drops the next cycle.
- Assert rst asynchronously mid-BUSY (between edges) -> s_valid, grant_o, busy_o and m_done go 0 immediately; after release, master 0 wins a simultaneous 0/1 request.
- With SIMP_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, slave never asserts done -> m_done[g] pulses after 8 BUSY cycles with 0xDEADBEEF, timeout_err_o=1 and stays 1; the next request is served normally.
- s_done coincides with a new m_valid from the other master -> one IDLE cycle, then the other master is granted, with no double done.
